uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 10416, meaning clock_in cycles per serial bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 The module SHALL have port clock_in, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, meaning reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port req0_valid, input, 1, meaning requester 0 has a byte to send.
REQ-005 The module SHALL have port req0_data, input, 8, meaning requester 0 byte.
REQ-006 The module SHALL have port req0_ready, output, 1, meaning requester 0 byte accepted this cycle.
REQ-007 The module SHALL have port req1_valid, input, 1, meaning requester 1 has a byte to send.
REQ-008 The module SHALL have port req1_data, input, 8, meaning requester 1 byte.
REQ-009 The module SHALL have port req1_ready, output, 1, meaning requester 1 byte accepted this cycle.
REQ-010 The module SHALL have port tx, output, 1, meaning the serial line, idle high.
REQ-011 The module SHALL have port busy, output, 1, meaning a frame is in progress (any state other than IDLE).
REQ-012 The module SHALL have port grant_id, output, 1, meaning the requester owning the current or most recent frame.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY (present only with UART_TX_PARITY_EN), and STOP.
REQ-014 A transfer SHALL occur when reqN_valid and reqN_ready are both high on a rising edge; reqN_ready SHALL be high only in IDLE, and only for the requester selected in that cycle.
REQ-015 In IDLE with exactly one valid, that requester SHALL be selected; with both valid, the requester not equal to last_grant SHALL be selected (round robin).
REQ-016 On a transfer, the module SHALL latch the byte into a shift register, set grant_id and last_grant to the winner, clear the baud counter, and enter START.
REQ-017 tx SHALL go low on the first clock after the transfer.
REQ-018 The 16-bit baud counter SHALL count 0..CLK_DIV-1 only while busy, and each bit period SHALL end when count == CLK_DIV-1; the counter SHALL then wrap to 0.
REQ-019 START SHALL drive tx=0 for CLK_DIV cycles, then enter DATA.
REQ-020 DATA SHALL drive 8 bits LSB first, each for CLK_DIV cycles, using a 3-bit index, then enter PARITY if compiled in, else STOP.
REQ-021 STOP SHALL drive tx=1 for CLK_DIV cycles, then enter IDLE.
REQ-022 A frame SHALL last exactly 10*CLK_DIV cycles, or 11*CLK_DIV with parity.
REQ-023 After STOP, IDLE SHALL last at least 1 cycle before the next transfer, so back-to-back frames are spaced 10*CLK_DIV+1 cycles (11*CLK_DIV+1 with parity).
REQ-024 While busy, valid inputs SHALL be ignored (ready stays low), and a requester SHALL hold valid and data until its transfer occurs.
REQ-025 A requester deasserting valid before its ready SHALL cause no transfer and no change of state.
REQ-026 tx, req0_ready and req1_ready SHALL be driven from registers or IDLE-state decode only, so no combinational path exists from data inputs to tx.

Reset
REQ-027 While rst_n=0, the module SHALL force IDLE, tx=1, busy=0, req0_ready=0, req1_ready=0, grant_id=0, last_grant=1, baud counter=0, bit index=0, and shift register=0.
REQ-028 Assertion of rst_n mid-frame SHALL abort the frame immediately (tx=1 asynchronously), and the aborted byte SHALL be discarded.
REQ-029 After rst_n deasserts, the first tied request SHALL go to requester 0.

Configuration
REQ-030 With macro UART_TX_PARITY_EN defined, the module SHALL insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
REQ-031 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification (CLK_DIV=4)
REQ-032 Single byte: req0 sends 0xA5 with no parity -> tx is 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; busy is high for 40 cycles; grant_id=0.
REQ-033 Tie: both requesters valid from reset with req0=0x11 and req1=0x22 -> frame 0x11 (grant 0) is sent, then frame 0x22 (grant 1) follows, with the next start bit 41 cycles after the first.
REQ-034 Fairness: both requesters held valid for 4 frames -> grant_id sequence is 0,1,0,1.
REQ-035 Reset mid-DATA: rst_n low at cycle 15 of a frame -> tx=1 and busy=0 in the same cycle; after release, req1 alone sends 0x3C correctly.
REQ-036 Parity (macro defined): req1 sends 0x07 -> after the data bits a parity bit of 1 is sent for 4 cycles, and the frame is 44 cycles.
REQ-037 Valid withdrawn: req0_valid pulses for 1 cycle while busy -> no ready, no extra frame.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester handshake and serial-line bundle for uart_tx_scheduler
interface uart_tx_scheduler_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx;
    logic       busy;
    logic       grant_id;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, tx, busy, grant_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, tx, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-requester round-robin UART transmitter, even parity bit under UART_TX_PARITY_EN
module uart_tx_scheduler #(
    parameter int unsigned CLK_DIV = 10416
) (
    input  logic               clock_in,
    input  logic               rst_n,
    uart_tx_scheduler_if.slave bus
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        idle;
    logic        sel;
    logic        ready0;
    logic        ready1;
    logic        xfer;
    logic        bit_end;

    assign idle    = (state_q == IDLE);
    assign bit_end = (cnt_q == BIT_LAST);

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            sel = ~last_q;
        end else if (bus.req1_valid) begin
            sel = 1'b1;
        end
    end

    // Ready is an IDLE decode only; rst_n gating keeps it low while reset is held.
    assign ready0 = rst_n & idle & bus.req0_valid & ~sel;
    assign ready1 = rst_n & idle & bus.req1_valid & sel;
    assign xfer   = ready0 | ready1;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.tx         = tx_q;
    assign bus.busy       = ~idle;
    assign bus.grant_id   = grant_q;

    // Next-state logic: tx_d is the line level for the state being entered, so tx is a pure register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        grant_d = grant_q;
        last_d  = last_q;

        if (!idle) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (xfer) begin
                    shreg_d = sel ? bus.req1_data : bus.req0_data;
                    grant_d = sel;
                    last_d  = sel;
                    idx_d   = 3'd0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shreg_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shreg_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame at once and drops the byte in flight.
    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler at CLK_DIV=4
module tb_uart_tx_scheduler;

    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    typedef struct {
        logic       grant;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic rst;
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } vec_t;

    logic clock_in;
    logic rst_n;
    uart_tx_scheduler_if b();

    uart_tx_scheduler #(.CLK_DIV(DIV)) dut (
        .clock_in (clock_in),
        .rst_n    (rst_n),
        .bus      (b)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    exp_t       sb[$];
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    logic       mon_grant = 1'b0;
    logic [NB-1:0] mon_bits = '0;
    int         busy_run = 0;
    int         prev_start = -1;
    int         last_gap = 0;
    int         frames = 0;

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    initial begin
        forever begin
            @(posedge clock_in);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic frame_done();
        exp_t e;
        frames++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got data %0h expected no frame", mon_bits[8:1]);
        end else begin
            e = sb.pop_front();
            check("start_bit", 32'(mon_bits[0]), 32'd0);
            check("data_bits", 32'(mon_bits[8:1]), 32'(e.data));
`ifdef UART_TX_PARITY_EN
            check("parity_bit", 32'(mon_bits[9]), 32'(^e.data));
`endif
            check("stop_bit", 32'(mon_bits[NB-1]), 32'd1);
            check("grant_id", 32'(mon_grant), 32'(e.grant));
        end
    endtask

    // Serial-line monitor: decodes frames mid-bit and measures busy length and start spacing.
    initial begin
        forever begin
            @(negedge clock_in);
            if (!rst_n) begin
                mon_active = 1'b0;
                busy_run   = 0;
            end else begin
                if (b.busy) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    check("busy_len", 32'(busy_run), 32'(FRAME));
                    busy_run = 0;
                end
                if (!mon_active && b.tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_grant  = b.grant_id;
                    if (prev_start >= 0) last_gap = cyc - prev_start;
                    prev_start = cyc;
                end
                if (mon_active) begin
                    if (mon_cnt % DIV == DIV / 2) mon_bits[mon_cnt / DIV] = b.tx;
                    if (mon_cnt == FRAME - 1) begin
                        mon_active = 1'b0;
                        frame_done();
                    end else begin
                        mon_cnt++;
                    end
                end
            end
        end
    end

    task automatic send(input int id, input logic [7:0] d, input int budget);
        logic rdy;
        logic done;
        done = 1'b0;
        if (id == 0) begin b.req0_valid = 1'b1; b.req0_data = d; end
        else         begin b.req1_valid = 1'b1; b.req1_data = d; end
        for (int i = 0; i < budget && !done; i++) begin
            #1;
            rdy = (id == 0) ? b.req0_ready : b.req1_ready;
            @(posedge clock_in);
            if (rdy) done = 1'b1;
            else @(negedge clock_in);
        end
        #1;
        if (id == 0) b.req0_valid = 1'b0;
        else         b.req1_valid = 1'b0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock_in);
            #1;
            if (sb.size() == 0 && !mon_active && !b.busy) ok = 1'b1;
        end
        check("idle_reached", 32'(ok), 32'd1);
        repeat (2) @(negedge clock_in);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   f0;

        vecs[0] = '{rst: 1'b0, v0: 1'b1, v1: 1'b1, r0: 1'b0, r1: 1'b0};
        vecs[1] = '{rst: 1'b1, v0: 1'b0, v1: 1'b0, r0: 1'b0, r1: 1'b0};
        vecs[2] = '{rst: 1'b1, v0: 1'b1, v1: 1'b0, r0: 1'b1, r1: 1'b0};
        vecs[3] = '{rst: 1'b1, v0: 1'b0, v1: 1'b1, r0: 1'b0, r1: 1'b1};
        vecs[4] = '{rst: 1'b1, v0: 1'b1, v1: 1'b1, r0: 1'b1, r1: 1'b0};

        rst_n        = 1'b0;
        b.req0_valid = 1'b0;
        b.req0_data  = 8'h00;
        b.req1_valid = 1'b0;
        b.req1_data  = 8'h00;

        // Idle/reset vectors: valids pulsed mid-cycle and withdrawn before the edge.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock_in);
            rst_n        = vecs[i].rst;
            b.req0_valid = vecs[i].v0;
            b.req1_valid = vecs[i].v1;
            #1;
            check("vec_r0", 32'(b.req0_ready), 32'(vecs[i].r0));
            check("vec_r1", 32'(b.req1_ready), 32'(vecs[i].r1));
            check("vec_tx", 32'(b.tx), 32'd1);
            check("vec_busy", 32'(b.busy), 32'd0);
            check("vec_grant", 32'(b.grant_id), 32'd0);
            #1;
            b.req0_valid = 1'b0;
            b.req1_valid = 1'b0;
        end
        @(posedge clock_in);
        #1;
        check("withdraw_idle_busy", 32'(b.busy), 32'd0);

        // Single byte from requester 0.
        @(negedge clock_in);
        sb.push_back('{grant: 1'b0, data: 8'hA5});
        send(0, 8'hA5, 20);
        wait_idle(200);

        // Tie from reset: requester 0 first, then requester 1 one idle cycle after the stop bit.
        @(negedge clock_in);
        rst_n = 1'b0;
        @(negedge clock_in);
        sb.push_back('{grant: 1'b0, data: 8'h11});
        sb.push_back('{grant: 1'b1, data: 8'h22});
        rst_n = 1'b1;
        fork
            send(0, 8'h11, 200);
            send(1, 8'h22, 200);
        join
        wait_idle(200);
        check("tie_gap", 32'(last_gap), 32'(FRAME + 1));

        // Fairness: both requesters keep a byte pending for four frames.
        @(negedge clock_in);
        sb.push_back('{grant: 1'b0, data: 8'h31});
        sb.push_back('{grant: 1'b1, data: 8'h32});
        sb.push_back('{grant: 1'b0, data: 8'h33});
        sb.push_back('{grant: 1'b1, data: 8'h34});
        fork
            begin send(0, 8'h31, 400); send(0, 8'h33, 400); end
            begin send(1, 8'h32, 400); send(1, 8'h34, 400); end
        join
        wait_idle(400);

        // Reset during DATA: the line must return high within the same cycle.
        @(negedge clock_in);
        send(0, 8'h5A, 20);
        repeat (14) @(posedge clock_in);
        #2;
        b.req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(b.tx), 32'd1);
        check("rst_busy", 32'(b.busy), 32'd0);
        check("rst_r0", 32'(b.req0_ready), 32'd0);
        check("rst_r1", 32'(b.req1_ready), 32'd0);
        b.req1_valid = 1'b0;
        @(negedge clock_in);
        @(negedge clock_in);
        rst_n = 1'b1;
        @(negedge clock_in);
        sb.push_back('{grant: 1'b1, data: 8'h3C});
        send(1, 8'h3C, 20);
        wait_idle(200);

`ifdef UART_TX_PARITY_EN
        @(negedge clock_in);
        sb.push_back('{grant: 1'b1, data: 8'h07});
        send(1, 8'h07, 20);
        wait_idle(200);
`endif

        // Valid pulsed while busy: no ready, no extra frame.
        @(negedge clock_in);
        f0 = frames;
        sb.push_back('{grant: 1'b1, data: 8'h96});
        send(1, 8'h96, 20);
        repeat (10) @(negedge clock_in);
        b.req0_valid = 1'b1;
        b.req0_data  = 8'hFF;
        #1;
        check("busy_ready", 32'(b.req0_ready), 32'd0);
        @(posedge clock_in);
        #1;
        b.req0_valid = 1'b0;
        wait_idle(200);
        repeat (60) @(negedge clock_in);
        check("no_extra_frame", 32'(frames - f0), 32'd1);
        check("final_busy", 32'(b.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
